// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register word offsets and the
// width of the register address bus.
package gpio_pkg;

  localparam int ADDR_W = 4;

  // Register word offsets
  localparam logic [ADDR_W-1:0] REG_DDR      = 4'd0;  // direction, 1 = output
  localparam logic [ADDR_W-1:0] REG_PORT     = 4'd1;  // output value
  localparam logic [ADDR_W-1:0] REG_PIN      = 4'd2;  // synchronised pin state, read-only
  localparam logic [ADDR_W-1:0] REG_PORT_SET = 4'd3;  // write-only, PORT |= wd
  localparam logic [ADDR_W-1:0] REG_PORT_CLR = 4'd4;  // write-only, PORT &= ~wd
  localparam logic [ADDR_W-1:0] REG_PORT_TGL = 4'd5;  // write-only, PORT ^= wd
  localparam logic [ADDR_W-1:0] REG_RISE_EN  = 4'd6;  // rising-edge interrupt enable
  localparam logic [ADDR_W-1:0] REG_FALL_EN  = 4'd7;  // falling-edge interrupt enable
  localparam logic [ADDR_W-1:0] REG_PEND     = 4'd8;  // pending edges, write 1 to clear

endpackage

// File: rtl/gpio_sync.sv
// Per-bit multi-flop synchroniser. The last flop of the chain is the
// architecturally visible PIN register, so a change on d shows up on q
// exactly STAGES rising edges later. Intended STAGES range is 2..4.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  // Shift the sampled pins down the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: direction/output registers with atomic set/clear/toggle,
// synchronised pin readback, and per-bit rising/falling edge interrupts.
//
// Register bus: there is no back-pressure. A write is accepted on every clk
// edge where we=1 (addr/wd sampled on that edge); rd is a pure combinational
// function of addr and the current register state, and reading never
// changes state.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wd,
  output logic [WIDTH-1:0]  rd,
  inout  wire  [WIDTH-1:0]  ioport,
  output logic              irq
);

  logic [WIDTH-1:0] ddr_q;
  logic [WIDTH-1:0] port_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pin;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pend_set;
  logic [WIDTH-1:0] pend_clr;

  // Pins are sampled whatever their direction, so outputs read back the
  // value actually on the pad.
  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ioport),
    .q   (pin)
  );

  // Per-bit tristate pad drivers: drive PORT where DDR marks an output.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign ioport[i] = ddr_q[i] ? port_q[i] : 1'bz;
  end

  // Control register writes, including the atomic PORT set/clear/toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ddr_q     <= '0;
      port_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (we) begin
      case (addr)
        REG_DDR:      ddr_q     <= wd;
        REG_PORT:     port_q    <= wd;
        REG_PORT_SET: port_q    <= port_q | wd;
        REG_PORT_CLR: port_q    <= port_q & ~wd;
        REG_PORT_TGL: port_q    <= port_q ^ wd;
        REG_RISE_EN:  rise_en_q <= wd;
        REG_FALL_EN:  fall_en_q <= wd;
        default: ;
      endcase
    end
  end

  // PREV trails PIN by one cycle. Both reset to 0, so a pin that is high
  // out of reset only counts as a rising edge once PIN itself goes to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= pin;
    end
  end

  // Edge detection is only ever on synchronised state; enables gate the
  // current edge, so enabling never catches an edge that already happened.
  always_comb begin
    rise     = pin & ~prev_q;
    fall     = ~pin & prev_q;
    pend_set = (rise & rise_en_q) | (fall & fall_en_q);
    pend_clr = (we && (addr == REG_PEND)) ? wd : '0;
  end

  // Pending flags: write-1-to-clear, with a new edge winning over a clear
  // in the same cycle so no event is ever dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  assign irq = |pend_q;

  // Read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rd = '0;
    case (addr)
      REG_DDR:     rd = ddr_q;
      REG_PORT:    rd = port_q;
      REG_PIN:     rd = pin;
      REG_RISE_EN: rd = rise_en_q;
      REG_FALL_EN: rd = fall_en_q;
      REG_PEND:    rd = pend_q;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl. Drivers push the hand-computed expected
// value for each observation into a queue and raise chk_valid; the monitor
// pops and compares on the falling edge while chk_valid is high.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int W = 32;
  localparam int S = 2;

  localparam int SEL_RD  = 0;
  localparam int SEL_IRQ = 1;
  localparam int SEL_IO  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [3:0]    addr;
  logic [W-1:0]  wd;
  logic [W-1:0]  rd;
  wire  [W-1:0]  ioport;
  logic          irq;

  // External pin drivers (the "board")
  logic [W-1:0]  ext_en;
  logic [W-1:0]  ext_val;

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign ioport[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  gpio_ctrl #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .addr   (addr),
    .wd     (wd),
    .rd     (rd),
    .ioport (ioport),
    .irq    (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           sel_q[$];
  string        name_q[$];
  logic         chk_valid;
  int           checks   = 0;
  int           failures = 0;

  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_mask;
  logic [W-1:0] mon_act;
  int           mon_sel;
  string        mon_name;

  always @(negedge clk) begin
    if (chk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL monitor: observation with empty expected queue");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_mask = mask_q.pop_front();
        mon_sel  = sel_q.pop_front();
        mon_name = name_q.pop_front();
        case (mon_sel)
          SEL_RD:  mon_act = rd;
          SEL_IRQ: mon_act = {{(W-1){1'b0}}, irq};
          default: mon_act = ioport;
        endcase
        if ((mon_act & mon_mask) !== (mon_exp & mon_mask)) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", mon_name,
                   mon_act & mon_mask, mon_exp & mon_mask);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    we   = 1'b1;
    addr = a;
    wd   = d;
    tick();
    we   = 1'b0;
    wd   = '0;
  endtask

  // Observation in the current cycle, sampled on the next falling edge.
  task automatic expect_out(input int sel, input logic [3:0] a,
                            input logic [W-1:0] m, input logic [W-1:0] e,
                            input string nm);
    addr = a;
    exp_q.push_back(e);
    mask_q.push_back(m);
    sel_q.push_back(sel);
    name_q.push_back(nm);
    chk_valid = 1'b1;
    @(negedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic expect_rd(input logic [3:0] a, input logic [W-1:0] e, input string nm);
    expect_out(SEL_RD, a, '1, e, nm);
  endtask

  task automatic expect_irq(input logic e, input string nm);
    expect_out(SEL_IRQ, 4'd0, '1, {{(W-1){1'b0}}, e}, nm);
  endtask

  task automatic expect_io(input logic [W-1:0] m, input logic [W-1:0] e, input string nm);
    expect_out(SEL_IO, 4'd0, m, e, nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    we        = 1'b0;
    addr      = '0;
    wd        = '0;
    chk_valid = 1'b0;
    ext_en    = '1;
    ext_val   = '0;
    ticks(3);
    rst = 1'b0;

    // Reset state: every offset reads 0, no interrupt
    for (int a = 0; a < 16; a++) begin
      logic [3:0] a4;
      a4 = a[3:0];
      expect_rd(a4, '0, $sformatf("reset_rd_%0d", a));
    end
    expect_irq(1'b0, "reset_irq");

    // Scenario 1: low byte as outputs, upper bits driven externally
    ext_val = 32'h1234_5600;
    wr(REG_DDR, 32'h0000_00FF);
    ext_en = ~32'h0000_00FF;
    wr(REG_PORT, 32'h0000_00A5);
    expect_io(32'h0000_00FF, 32'h0000_00A5, "s1_io_low");
    expect_rd(REG_PIN, 32'h1234_5600, "s1_pin_one_edge");
    expect_rd(REG_PIN, 32'h1234_56A5, "s1_pin_two_edges");
    expect_rd(REG_DDR, 32'h0000_00FF, "s1_ddr");
    expect_rd(REG_PORT, 32'h0000_00A5, "s1_port");

    // Scenario 2: atomic set / clear / toggle
    wr(REG_PORT, 32'h0000_000F);
    wr(REG_PORT_SET, 32'h0000_00F0);
    wr(REG_PORT_CLR, 32'h0000_0003);
    expect_rd(REG_PORT, 32'h0000_00FC, "s2_port_set_clr");
    wr(REG_PORT_TGL, 32'h0000_0011);
    expect_rd(REG_PORT, 32'h0000_00ED, "s2_port_tgl");
    expect_io(32'h0000_00FF, 32'h0000_00ED, "s2_io_low");
    expect_rd(REG_PORT_SET, '0, "s2_rd_set_zero");
    expect_rd(REG_PORT_CLR, '0, "s2_rd_clr_zero");
    expect_rd(REG_PORT_TGL, '0, "s2_rd_tgl_zero");
    // Writes to PIN and unmapped offsets have no effect
    wr(REG_PIN, '1);
    wr(4'd9, '1);
    wr(4'd15, '1);
    expect_rd(REG_DDR, 32'h0000_00FF, "s2_ddr_kept");
    expect_rd(REG_PORT, 32'h0000_00ED, "s2_port_kept");
    expect_rd(REG_RISE_EN, '0, "s2_rise_kept");
    expect_rd(REG_FALL_EN, '0, "s2_fall_kept");
    expect_rd(REG_PEND, '0, "s2_pend_kept");
    expect_rd(REG_PIN, 32'h1234_56ED, "s2_pin_readback");
    expect_rd(4'd9, '0, "s2_rd_9_zero");
    expect_rd(4'd15, '0, "s2_rd_15_zero");

    // Scenario 3: rising edge on pin 0, latency SYNC_STAGES+1 to irq
    wr(REG_DDR, '0);
    ext_en  = '1;
    ext_val = 32'h1234_5600;
    wr(REG_RISE_EN, 32'h0000_0001);
    ticks(3);
    expect_rd(REG_PEND, '0, "s3_pend_idle");
    tick();                              // edge N
    ext_val[0] = 1'b1;
    tick();                              // edge N+1
    expect_irq(1'b0, "s3_irq_n1");
    expect_irq(1'b0, "s3_irq_n2");       // cycle after edge N+2
    expect_irq(1'b1, "s3_irq_n3");       // cycle after edge N+3
    expect_rd(REG_PEND, 32'h0000_0001, "s3_pend_set");
    wr(REG_PEND, 32'h0000_0001);
    expect_irq(1'b0, "s3_irq_w1c");
    expect_rd(REG_PEND, '0, "s3_pend_w1c");

    // Scenario 4: falling edge on pin 1 colliding with its W1C
    ext_val[1] = 1'b1;
    ticks(4);
    wr(REG_FALL_EN, 32'h0000_0002);
    tick();
    expect_rd(REG_PEND, '0, "s4_pend_no_retro");
    tick();
    ext_val[1] = 1'b0;
    ticks(4);
    expect_rd(REG_PEND, 32'h0000_0002, "s4_pend_fall");
    wr(REG_PEND, 32'h0000_0002);
    expect_rd(REG_PEND, '0, "s4_pend_cleared");
    ext_val[1] = 1'b1;
    ticks(4);                            // edge K
    ext_val[1] = 1'b0;
    tick();                              // edge K+1
    tick();                              // edge K+2: fall now visible
    wr(REG_PEND, 32'h0000_0002);         // edge K+3: set and W1C together
    expect_rd(REG_PEND, 32'h0000_0002, "s4_set_beats_w1c");
    wr(REG_PEND, 32'h0000_0002);
    expect_rd(REG_PEND, '0, "s4_pend_after_w1c");
    expect_irq(1'b0, "s4_irq_low");

    // Scenario 6: enabling on an already-high pin does not set PEND
    ext_val[2] = 1'b1;
    ticks(4);
    wr(REG_RISE_EN, 32'h0000_0004);
    ticks(3);
    expect_rd(REG_PEND, '0, "s6_pend_no_retro");
    tick();
    ext_val[2] = 1'b0;
    ticks(4);
    ext_val[2] = 1'b1;
    ticks(4);
    expect_rd(REG_PEND, 32'h0000_0004, "s6_pend_toggle");
    expect_irq(1'b1, "s6_irq");

    // Scenario 5: reset wins over a concurrent write
    wr(REG_PEND, '1);
    expect_rd(REG_PEND, '0, "s5_pend_clear_all");
    wr(REG_RISE_EN, 32'h0000_0001);
    ext_val[0] = 1'b0;
    ext_val[1] = 1'b1;
    ticks(4);
    expect_rd(REG_PEND, '0, "s5_pend_quiet");
    ext_val[0] = 1'b1;
    ext_val[1] = 1'b0;
    ticks(4);
    expect_rd(REG_PEND, 32'h0000_0003, "s5_pend_both");
    wr(REG_DDR, 32'h0000_00FF);
    ext_en = ~32'h0000_00FF;
    expect_rd(REG_DDR, 32'h0000_00FF, "s5_ddr_before");
    expect_rd(REG_PEND, 32'h0000_0003, "s5_pend_before");
    rst  = 1'b1;
    we   = 1'b1;
    addr = REG_DDR;
    wd   = '1;
    tick();
    rst     = 1'b0;
    we      = 1'b0;
    wd      = '0;
    ext_en  = '1;
    ext_val = '0;
    for (int a = 0; a < 9; a++) begin
      logic [3:0] a4;
      a4 = a[3:0];
      expect_rd(a4, '0, $sformatf("s5_reset_rd_%0d", a));
    end
    expect_irq(1'b0, "s5_irq");
    expect_io('1, '0, "s5_io_released");

    // ---------------- final report ----------------
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures += exp_q.size();
      $display("FAIL drain: %0d observations never compared, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
